// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner/state encodings
// for the RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_VID = 2'd1,
        OWN_DMA = 2'd2
    } owner_t;

    typedef enum logic {
        SEL  = 1'b0,
        DATA = 1'b1
    } state_t;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: fixed-priority slot winner,
// with the CPU forced in once the guard is full.
import mem_arb_pkg::*;

module arb_pick (
    input  logic   vid_req,
    input  logic   dma_req,
    input  logic   guard_full,
    output owner_t owner
);

    // guard beats video beats DMA; CPU fills idle slots
    always_comb begin
        owner = OWN_CPU;
        priority case (1'b1)
            guard_full: owner = OWN_CPU;
            vid_req:    owner = OWN_VID;
            dma_req:    owner = OWN_DMA;
            default:    owner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-cycle slots (SEL, DATA) sharing
// one byte RAM port between CPU, video and DMA.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int CPU_GUARANTEE = 4,
    parameter int AW            = 20
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_out,
    input  logic          cpu_we,
    output logic [7:0]    cpu_in,
    output logic          cpu_ce,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_address,
    output logic          vid_ack,
    output logic [7:0]    vid_data,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_address,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] mem_address,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);

    localparam int GW = $clog2(CPU_GUARANTEE + 1);
    localparam logic [GW-1:0] GMAX = GW'(CPU_GUARANTEE);

    state_t        state;
    owner_t        owner;
    owner_t        winner;
    logic [GW-1:0] guard;
    logic          guard_full;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    cpu_in_q;
    logic [7:0]    vid_data_q;
    logic [7:0]    dma_rdata_q;
    logic [AW-1:0] win_addr;
    logic [7:0]    win_wdata;
    logic          win_we;
    logic          sel_act;
    logic          dat_act;

    assign guard_full = (guard == GMAX);

    arb_pick u_pick (
        .vid_req    (vid_req),
        .dma_req    (dma_req),
        .guard_full (guard_full),
        .owner      (winner)
    );

    // RAM request of whichever requester wins this SEL
    always_comb begin
        win_addr  = cpu_address;
        win_wdata = cpu_out;
        win_we    = cpu_we;
        case (winner)
            OWN_VID: begin
                win_addr  = vid_address;
                win_wdata = 8'h00;
                win_we    = 1'b0;
            end
            OWN_DMA: begin
                win_addr  = dma_address;
                win_wdata = dma_wdata;
                win_we    = dma_we;
            end
            default: ;
        endcase
    end

    // slot FSM, guard counter and per-owner data holding
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= SEL;
            owner       <= OWN_CPU;
            guard       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_in_q    <= '0;
            vid_data_q  <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                SEL: begin
                    owner   <= winner;
                    addr_q  <= win_addr;
                    wdata_q <= win_wdata;
                    state   <= DATA;
                    if (winner == OWN_CPU)
                        guard <= '0;
                    else if (!guard_full)
                        guard <= guard + GW'(1);
                end
                DATA: begin
                    state <= SEL;
                    case (owner)
                        OWN_VID: vid_data_q  <= mem_rdata;
                        OWN_DMA: dma_rdata_q <= mem_rdata;
                        default: cpu_in_q    <= mem_rdata;
                    endcase
                end
                default: state <= SEL;
            endcase
        end
    end

    // reset_n masks everything at once, so a slot
    // caught by reset never pulses its ack
    always_comb begin
        sel_act     = reset_n && (state == SEL);
        dat_act     = reset_n && (state == DATA);
        cpu_ce      = dat_act && (owner == OWN_CPU);
        vid_ack     = dat_act && (owner == OWN_VID);
        dma_ack     = dat_act && (owner == OWN_DMA);
        mem_we      = sel_act && win_we;
        mem_address = '0;
        mem_wdata   = '0;
        if (sel_act) begin
            mem_address = win_addr;
            mem_wdata   = win_wdata;
        end else if (reset_n) begin
            mem_address = addr_q;
            mem_wdata   = wdata_q;
        end
        cpu_in    = !reset_n ? 8'h00 :
                    cpu_ce ? mem_rdata : cpu_in_q;
        vid_data  = !reset_n ? 8'h00 :
                    vid_ack ? mem_rdata : vid_data_q;
        dma_rdata = !reset_n ? 8'h00 :
                    dma_ack ? mem_rdata : dma_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle table for slot sequencing plus
// hand sequences for CPU write and DMA write/read.
module tb_mem_arbiter;

    localparam logic [19:0] CA = 20'h12345;
    localparam logic [19:0] VA = 20'h00100;
    localparam logic [19:0] DA = 20'h00200;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        cpu_ce;
    logic        vid_req;
    logic [19:0] vid_address;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic        dma_req;
    logic        dma_we;
    logic [19:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0] ram [0:(1<<20)-1];

    int passed = 0;
    int total  = 0;
    int wr_cnt;

    typedef struct {
        logic        rst_n;
        logic        vreq;
        logic        dreq;
        logic        ce;
        logic        vack;
        logic        dack;
        logic        mwe;
        logic [19:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t tbl[$];

    mem_arbiter #(.CPU_GUARANTEE(4), .AW(20)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_in      (cpu_in),
        .cpu_ce      (cpu_ce),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_ack     (vid_ack),
        .vid_data    (vid_data),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_address (dma_address),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    // synchronous RAM, one cycle read latency
    always @(posedge clock) begin
        if (mem_we)
            ram[mem_address] <= mem_wdata;
        mem_rdata <= ram[mem_address];
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
    endtask

    task automatic add(input logic r, input logic vq,
                       input logic dq, input logic ce,
                       input logic va, input logic da,
                       input logic we,
                       input logic [19:0] a,
                       input logic [7:0] d);
        vec_t v;
        v.rst_n = r;  v.vreq = vq; v.dreq = dq;
        v.ce    = ce; v.vack = va; v.dack = da;
        v.mwe   = we; v.addr = a;  v.data = d;
        tbl.push_back(v);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cpu_ce"},    32'(cpu_ce),      0);
        chk({tag, " vid_ack"},   32'(vid_ack),     0);
        chk({tag, " dma_ack"},   32'(dma_ack),     0);
        chk({tag, " mem_we"},    32'(mem_we),      0);
        chk({tag, " mem_addr"},  32'(mem_address), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata),   0);
        chk({tag, " cpu_in"},    32'(cpu_in),      0);
        chk({tag, " vid_data"},  32'(vid_data),    0);
        chk({tag, " dma_rdata"}, 32'(dma_rdata),   0);
    endtask

    initial begin
        for (int i = 0; i < (1 << 20); i++)
            ram[i] = 8'h00;
        ram[CA]       = 8'h5A;
        ram[VA]       = 8'h11;
        ram[DA]       = 8'h22;
        ram[20'h0]    = 8'h77;

        reset_n     = 1'b0;
        cpu_address = CA;
        cpu_out     = 8'h00;
        cpu_we      = 1'b0;
        vid_req     = 1'b0;
        vid_address = VA;
        dma_req     = 1'b0;
        dma_we      = 1'b0;
        dma_address = DA;
        dma_wdata   = 8'h00;

        // idle CPU-only slots
        add(1,0,0, 0,0,0,0, CA, 8'h00);
        add(1,0,0, 1,0,0,0, CA, 8'h5A);
        add(1,0,0, 0,0,0,0, CA, 8'h00);
        add(1,0,0, 1,0,0,0, CA, 8'h5A);
        // video held: V,V,V,V then forced C, then V
        for (int k = 0; k < 4; k++) begin
            add(1,1,0, 0,0,0,0, VA, 8'h00);
            add(1,1,0, 0,1,0,0, VA, 8'h11);
        end
        add(1,1,0, 0,0,0,0, CA, 8'h00);
        add(1,1,0, 1,0,0,0, CA, 8'h5A);
        add(1,1,0, 0,0,0,0, VA, 8'h00);
        add(1,1,0, 0,1,0,0, VA, 8'h11);
        add(1,0,0, 0,0,0,0, CA, 8'h00);
        add(1,0,0, 1,0,0,0, CA, 8'h5A);
        // video and DMA together: V, D, C
        add(1,1,1, 0,0,0,0, VA, 8'h00);
        add(1,1,1, 0,1,0,0, VA, 8'h11);
        add(1,0,1, 0,0,0,0, DA, 8'h00);
        add(1,0,1, 0,0,1,0, DA, 8'h22);
        add(1,0,0, 0,0,0,0, CA, 8'h00);
        // video rises during DATA, served next SEL
        add(1,1,0, 1,0,0,0, CA, 8'h5A);
        add(1,1,0, 0,0,0,0, VA, 8'h00);
        add(1,1,0, 0,1,0,0, VA, 8'h11);
        add(1,0,0, 0,0,0,0, CA, 8'h00);
        add(1,0,0, 1,0,0,0, CA, 8'h5A);
        // reset in the DATA of a video slot
        add(1,1,0, 0,0,0,0, VA, 8'h00);
        add(0,1,0, 0,0,0,0, 20'h0, 8'h00);
        add(1,1,0, 0,0,0,0, VA, 8'h00);
        add(1,1,0, 0,1,0,0, VA, 8'h11);
        add(1,0,0, 0,0,0,0, CA, 8'h00);
        add(1,0,0, 1,0,0,0, CA, 8'h5A);

        repeat (3) step();
        @(negedge clock);
        chk_reset_vals("reset");

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("row%0d", i + 1);
            step();
            reset_n = tbl[i].rst_n;
            vid_req = tbl[i].vreq;
            dma_req = tbl[i].dreq;
            @(negedge clock);
            chk({tag, " cpu_ce"},   32'(cpu_ce),  32'(tbl[i].ce));
            chk({tag, " vid_ack"},  32'(vid_ack), 32'(tbl[i].vack));
            chk({tag, " dma_ack"},  32'(dma_ack), 32'(tbl[i].dack));
            chk({tag, " mem_we"},   32'(mem_we),  32'(tbl[i].mwe));
            chk({tag, " mem_addr"}, 32'(mem_address),
                32'(tbl[i].addr));
            if (tbl[i].ce)
                chk({tag, " cpu_in"}, 32'(cpu_in),
                    32'(tbl[i].data));
            if (tbl[i].vack)
                chk({tag, " vid_data"}, 32'(vid_data),
                    32'(tbl[i].data));
            if (tbl[i].dack)
                chk({tag, " dma_rdata"}, 32'(dma_rdata),
                    32'(tbl[i].data));
            if (!tbl[i].rst_n)
                chk_reset_vals({tag, " midreset"});
        end

        // CPU write: one write per ce, then read back
        wr_cnt = 0;
        step();
        cpu_address = 20'h0FFFE;
        cpu_out     = 8'hA5;
        cpu_we      = 1'b1;
        @(negedge clock);
        wr_cnt += int'(mem_we);
        chk("cwr sel we",    32'(mem_we),      1);
        chk("cwr sel addr",  32'(mem_address), 32'h0FFFE);
        chk("cwr sel wdata", 32'(mem_wdata),   32'hA5);
        step();
        @(negedge clock);
        wr_cnt += int'(mem_we);
        chk("cwr data ce", 32'(cpu_ce), 1);
        chk("cwr data we", 32'(mem_we), 0);
        step();
        cpu_we = 1'b0;
        @(negedge clock);
        wr_cnt += int'(mem_we);
        chk("crd sel ce",   32'(cpu_ce),      0);
        chk("crd sel addr", 32'(mem_address), 32'h0FFFE);
        step();
        @(negedge clock);
        wr_cnt += int'(mem_we);
        chk("crd ce",     32'(cpu_ce), 1);
        chk("crd cpu_in", 32'(cpu_in), 32'hA5);
        chk("cwr count",  32'(wr_cnt), 1);
        chk("cwr ram",    32'(ram[20'h0FFFE]), 32'hA5);

        // DMA write then read at the top address
        step();
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 20'hFFFFF;
        dma_wdata   = 8'h3C;
        @(negedge clock);
        chk("dwr we",    32'(mem_we),      1);
        chk("dwr addr",  32'(mem_address), 32'hFFFFF);
        chk("dwr wdata", 32'(mem_wdata),   32'h3C);
        step();
        @(negedge clock);
        chk("dwr ack", 32'(dma_ack), 1);
        chk("dwr ce",  32'(cpu_ce),  0);
        step();
        dma_we = 1'b0;
        @(negedge clock);
        chk("drd we",   32'(mem_we),      0);
        chk("drd addr", 32'(mem_address), 32'hFFFFF);
        step();
        @(negedge clock);
        chk("drd ack",   32'(dma_ack),   1);
        chk("drd rdata", 32'(dma_rdata), 32'h3C);
        step();
        dma_req = 1'b0;
        @(negedge clock);
        chk("post sel addr", 32'(mem_address), 32'h0FFFE);
        chk("post sel ack",  32'(dma_ack),     0);
        step();
        @(negedge clock);
        chk("post ce",  32'(cpu_ce),   1);
        chk("ram top",  32'(ram[20'hFFFFF]), 32'h3C);
        chk("ram zero", 32'(ram[20'h00000]), 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
